// File: rtl/sector_write_fsm_pkg.sv
// Shared definitions for the sector write path and the read decoder:
// state encodings, CRC-16 polynomial and the serial CRC step.
package sector_write_fsm_pkg;

    typedef enum logic [2:0] {
        WS_IDLE = 3'd0,
        WS_PRE  = 3'd1,
        WS_SYNC = 3'd2,
        WS_DATA = 3'd3,
        WS_CRC  = 3'd4,
        WS_POST = 3'd5
    } ws_state_e;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam int          WORD_BITS  = 16;

    // One serial CRC-16 step; data bits are fed in transmission order (LSB first).
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic [15:0] shifted;
        shifted = {crc[14:0], 1'b0};
        if (crc[15] ^ din) begin
            crc16_step = shifted ^ CRC16_POLY;
        end else begin
            crc16_step = shifted;
        end
    endfunction

endpackage

// File: rtl/sector_write_fsm_crc16_serial.sv
// Bit-serial CRC-16 accumulator for the sector data field.
// Only built when SECTOR_CRC_GEN_EN is defined.
`ifdef SECTOR_CRC_GEN_EN
module crc16_serial
    import sector_write_fsm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        enable,
    input  logic        bit_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // Next CRC value: clear wins over a data step.
    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = 16'h0000;
        end else if (enable) begin
            crc_d = crc16_step(crc_q, bit_in);
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_q <= 16'h0000;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule
`endif

// File: rtl/sector_write_fsm.sv
// Serialises one floppy sector (preamble, sync, data, check word, postamble).
// Define SECTOR_CRC_GEN_EN to generate the check word as CRC-16; otherwise
// an extra FIFO word is sent verbatim in its place.
module sector_write_fsm
    import sector_write_fsm_pkg::*;
#(
    parameter int PREAMBLE_BITS  = 48,
    parameter int POSTAMBLE_BITS = 16,
    parameter int DATA_WORDS     = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bitTick,
    input  logic        beginWrite,
    input  logic        sectorPulse,
    input  logic [15:0] wordIn,
    input  logic        fifo_empty,
    output logic        fifo_rd,
    output logic        writeBit,
    output logic        writeBitStrobe,
    output logic        writeGate,
    output logic        underrun,
    output logic [2:0]  write_state
);

    localparam int MAX_PHASE = (PREAMBLE_BITS > POSTAMBLE_BITS) ?
                               ((PREAMBLE_BITS > WORD_BITS) ? PREAMBLE_BITS : WORD_BITS) :
                               ((POSTAMBLE_BITS > WORD_BITS) ? POSTAMBLE_BITS : WORD_BITS);
    localparam int CNT_W  = $clog2(MAX_PHASE) + 1;
    localparam int WORD_W = $clog2(DATA_WORDS) + 1;

    ws_state_e          state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]  word_cnt_q, word_cnt_d;
    logic [15:0]        shreg_q, shreg_d;
    logic               wbit_q, wbit_d;
    logic               strobe_q, strobe_d;
    logic               gate_q, gate_d;
    logic               rd_q, rd_d;
    logic               underrun_q, underrun_d;
    logic               load_s;
    logic [15:0]        ld_word_s;
    logic               crc_clear_s;
    logic               crc_en_s;

`ifdef SECTOR_CRC_GEN_EN
    logic [15:0]        crc_s;

    crc16_serial u_crc (
        .clk     (clk),
        .rst     (rst),
        .clear   (crc_clear_s),
        .enable  (crc_en_s),
        .bit_in  (shreg_q[0]),
        .crc_out (crc_s)
    );
`endif

    // A starved FIFO yields a zero word so bit timing never slips.
    assign ld_word_s = fifo_empty ? 16'h0000 : wordIn;

    // Next-state, bit selection and FIFO load control.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        shreg_d     = shreg_q;
        wbit_d      = wbit_q;
        strobe_d    = 1'b0;
        gate_d      = gate_q;
        underrun_d  = underrun_q;
        load_s      = 1'b0;
        crc_clear_s = 1'b0;
        crc_en_s    = 1'b0;

        if (sectorPulse) begin
            state_d = WS_IDLE;
            gate_d  = 1'b0;
            wbit_d  = 1'b0;
        end else begin
            case (state_q)
                WS_IDLE: begin
                    wbit_d = 1'b0;
                    gate_d = 1'b0;
                    if (beginWrite) begin
                        state_d     = WS_PRE;
                        gate_d      = 1'b1;
                        bit_cnt_d   = {CNT_W{1'b0}};
                        word_cnt_d  = {WORD_W{1'b0}};
                        shreg_d     = 16'h0000;
                        underrun_d  = 1'b0;
                        crc_clear_s = 1'b1;
                    end else begin
                        state_d = WS_IDLE;
                    end
                end
                WS_PRE: begin
                    if (bitTick) begin
                        wbit_d   = 1'b0;
                        strobe_d = 1'b1;
                        if (bit_cnt_q == CNT_W'(PREAMBLE_BITS - 1)) begin
                            bit_cnt_d = {CNT_W{1'b0}};
                            state_d   = WS_SYNC;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        strobe_d = 1'b0;
                    end
                end
                WS_SYNC: begin
                    if (bitTick) begin
                        wbit_d   = 1'b1;
                        strobe_d = 1'b1;
                        load_s   = 1'b1;
                        state_d  = WS_DATA;
                    end else begin
                        strobe_d = 1'b0;
                    end
                end
                WS_DATA: begin
                    if (bitTick) begin
                        wbit_d   = shreg_q[0];
                        strobe_d = 1'b1;
                        crc_en_s = 1'b1;
                        shreg_d  = {1'b0, shreg_q[15:1]};
                        if (bit_cnt_q == CNT_W'(WORD_BITS - 1)) begin
                            bit_cnt_d = {CNT_W{1'b0}};
                            if (word_cnt_q == WORD_W'(DATA_WORDS - 1)) begin
                                state_d    = WS_CRC;
                                word_cnt_d = {WORD_W{1'b0}};
`ifdef SECTOR_CRC_GEN_EN
                                load_s     = 1'b0;
`else
                                load_s     = 1'b1;
`endif
                            end else begin
                                word_cnt_d = word_cnt_q + WORD_W'(1);
                                load_s     = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        strobe_d = 1'b0;
                    end
                end
                WS_CRC: begin
                    if (bitTick) begin
                        strobe_d = 1'b1;
`ifdef SECTOR_CRC_GEN_EN
                        wbit_d   = crc_s[bit_cnt_q[3:0]];
`else
                        wbit_d   = shreg_q[0];
                        shreg_d  = {1'b0, shreg_q[15:1]};
`endif
                        if (bit_cnt_q == CNT_W'(WORD_BITS - 1)) begin
                            bit_cnt_d = {CNT_W{1'b0}};
                            state_d   = WS_POST;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        strobe_d = 1'b0;
                    end
                end
                WS_POST: begin
                    if (bitTick) begin
                        wbit_d   = 1'b0;
                        strobe_d = 1'b1;
                        if (bit_cnt_q == CNT_W'(POSTAMBLE_BITS - 1)) begin
                            bit_cnt_d = {CNT_W{1'b0}};
                            state_d   = WS_IDLE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        strobe_d = 1'b0;
                    end
                end
                default: begin
                    state_d = WS_IDLE;
                    gate_d  = 1'b0;
                    wbit_d  = 1'b0;
                end
            endcase
        end

        shreg_d    = load_s ? ld_word_s : shreg_d;
        rd_d       = load_s & ~fifo_empty;
        underrun_d = underrun_d | (load_s & fifo_empty);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= WS_IDLE;
            bit_cnt_q  <= {CNT_W{1'b0}};
            word_cnt_q <= {WORD_W{1'b0}};
            shreg_q    <= 16'h0000;
            wbit_q     <= 1'b0;
            strobe_q   <= 1'b0;
            gate_q     <= 1'b0;
            rd_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            shreg_q    <= shreg_d;
            wbit_q     <= wbit_d;
            strobe_q   <= strobe_d;
            gate_q     <= gate_d;
            rd_q       <= rd_d;
            underrun_q <= underrun_d;
        end
    end

    assign fifo_rd        = rd_q;
    assign writeBit       = wbit_q;
    assign writeBitStrobe = strobe_q;
    assign writeGate      = gate_q;
    assign underrun       = underrun_q;
    assign write_state    = state_q;

endmodule

// File: doc/sector_write_fsm.md
SECTOR_WRITE_FSM -- requirements
Module: sector_write_fsm

Interface
REQ-001 SHALL have parameter PREAMBLE_BITS, default 48, count of zero bits before the sync bit.
REQ-002 SHALL have parameter POSTAMBLE_BITS, default 16, count of zero bits after the data field.
REQ-003 SHALL have parameter DATA_WORDS, default 128, 16-bit data words per sector.
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port bitTick, input, 1, one-cycle enable marking each write bit slot.
REQ-007 SHALL have port beginWrite, input, 1, strobe from the read decoder after the header postamble.
REQ-008 SHALL have port sectorPulse, input, 1, abort and return to idle.
REQ-009 SHALL have port wordIn, input, 16, first-word-fall-through FIFO head, valid when fifo_empty=0.
REQ-010 SHALL have port fifo_empty, input, 1, computer-to-FPGA FIFO empty.
REQ-011 SHALL have port fifo_rd, output, 1, one-cycle pop of wordIn.
REQ-012 SHALL have port writeBit, output, 1, current NRZ bit to the MFM encoder.
REQ-013 SHALL have port writeBitStrobe, output, 1, one-cycle strobe when writeBit updates.
REQ-014 SHALL have port writeGate, output, 1, drive write enable.
REQ-015 SHALL have port underrun, output, 1, sticky FIFO-starved flag.
REQ-016 SHALL have port write_state, output, 3, current state for debug.

Function
REQ-017 SHALL implement states WS_IDLE, WS_PRE, WS_SYNC, WS_DATA, WS_CRC, WS_POST.
REQ-018 SHALL move WS_IDLE->WS_PRE on beginWrite, clearing underrun and all counters.
REQ-019 SHALL ignore beginWrite in any state other than WS_IDLE.
REQ-020 SHALL, on each bitTick in a non-idle state, register the next bit on writeBit and pulse writeBitStrobe in the same registered cycle, one clk after bitTick.
REQ-021 SHALL emit PREAMBLE_BITS zeros in WS_PRE, then one 1 bit in WS_SYNC.
REQ-022 SHALL load the shift register from wordIn and pulse fifo_rd on the bitTick carrying the sync bit and on the bitTick carrying the last bit of each data word except the final one.
REQ-023 SHALL shift data LSB first, DATA_WORDS*16 bits total in WS_DATA.
REQ-024 SHALL, if fifo_empty=1 at a load, load 0x0000, not pulse fifo_rd, set underrun, and keep bit timing unchanged.
REQ-025 SHALL emit 16 check bits LSB first in WS_CRC, then POSTAMBLE_BITS zeros in WS_POST, then return to WS_IDLE.
REQ-026 SHALL assert writeGate from entry to WS_PRE until the cycle after the last postamble strobe.
REQ-027 SHALL, on sectorPulse in any state, go to WS_IDLE next clk and drop writeGate, with sectorPulse taking priority over a simultaneous beginWrite.
REQ-028 SHALL hold writeBit=0 in WS_IDLE.

Reset
REQ-029 SHALL, while rst=0, force WS_IDLE, writeBit=0, writeBitStrobe=0, writeGate=0, fifo_rd=0, underrun=0, and zero all counters and the CRC register.
REQ-030 SHALL abandon any sector in progress on reset, with no further strobes.

Configuration
REQ-031 SHALL, with SECTOR_CRC_GEN_EN defined, compute CRC-16 (poly 0x8005, init 0x0000, LSB-first over data bits) and emit it in WS_CRC.
REQ-032 SHALL, without SECTOR_CRC_GEN_EN, pop word DATA_WORDS+1 from the FIFO and emit it verbatim in WS_CRC, with REQ-024 underrun rules applying.

Structure
REQ-033 SHALL place the WS_* state encodings and the CRC polynomial constant in the shared states include used by the read decoder.
REQ-034 SHALL put the CRC in sub-module crc16_serial (clk, rst, clear, enable, bit in, 16-bit crc out).

Verification
REQ-035 SHALL cover this scenario: beginWrite with 128 words in the FIFO and bitTick every 4 clk -> exactly 48+1+2048+16+16=2129 writeBitStrobes, 128 fifo_rd pulses, writeGate high throughout, underrun=0.
REQ-036 SHALL cover this scenario: all-zero data with SECTOR_CRC_GEN_EN -> 16 CRC bits all 0, and a single word 0x0001 followed by zeros -> CRC matching the bench model.
REQ-037 SHALL cover this scenario: FIFO empties after 100 words -> words 101-128 sent as 0x0000, underrun=1, 2129 strobes still produced.
REQ-038 SHALL cover this scenario: sectorPulse at data bit 500 -> WS_IDLE next clk, writeGate=0, no further strobes or fifo_rd.
REQ-039 SHALL cover this scenario: rst low mid-WS_CRC -> all outputs zero immediately, and a later beginWrite restarts a full sector.
REQ-040 SHALL cover this scenario: second beginWrite during WS_DATA -> ignored, sector length unchanged.
